// File: rtl/md_issue_ctrl.sv
// Execute-stage issue controller for the multiply/divide unit: turns decoded MD instructions
// into unit strobes, tracks the BUSY window, stalls on hazards and returns HI/LO read data.
module md_issue_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MD_VALID,
  input  logic [2:0]  MD_FUNC,
  input  logic [31:0] RS_DATA,
  input  logic [31:0] RT_DATA,
  input  logic        FLUSH,
  input  logic        MD_BUSY,
  input  logic [31:0] MD_HI,
  input  logic [31:0] MD_LO,
  output logic        MD_START,
  output logic [1:0]  MD_OP,
  output logic        MD_WE_HI,
  output logic        MD_WE_LO,
  output logic [31:0] MD_D1,
  output logic [31:0] MD_D2,
  output logic        STALL,
  output logic        RD_VALID,
  output logic [31:0] RD_DATA,
  output logic        DIV0,
  output logic        ERR
);

  typedef enum logic [1:0] {StIdle, StArm, StWait} state_e;

  localparam logic [3:0] WdMax = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wd_q, wd_d;
  logic        err_q, err_d;

  logic        valid;
  logic        in_idle;
  logic        is_muldiv;
  logic        start;
  logic [3:0]  wd_inc;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      wd_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    err_d     = err_q;
    wd_inc    = wd_q + 4'd1;
    valid     = MD_VALID & ~FLUSH;
    in_idle   = (state_q == StIdle);
    is_muldiv = ~MD_FUNC[2];
    // A unit still busy after a watchdog abort must not re-latch operands.
    start     = valid & in_idle & is_muldiv & ~MD_BUSY;

    MD_START = 1'b0;
    MD_OP    = 2'd0;
    MD_WE_HI = 1'b0;
    MD_WE_LO = 1'b0;
    MD_D1    = 32'd0;
    MD_D2    = 32'd0;
    STALL    = 1'b0;
    RD_VALID = 1'b0;
    RD_DATA  = 32'd0;
    DIV0     = 1'b0;
    ERR      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StArm;
      end
      StArm: begin
        state_d = StWait;
        wd_d    = 4'd0;
      end
      StWait: begin
        if (!MD_BUSY) begin
          state_d = StIdle;
          wd_d    = 4'd0;
        end else if (wd_inc == WdMax) begin
          state_d = StIdle;
          wd_d    = 4'd0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    // Every output is held low while reset is asserted.
    if (RESET_N) begin
      MD_START = start;
      MD_OP    = start ? MD_FUNC[1:0] : 2'd0;
      MD_WE_HI = valid & in_idle & (MD_FUNC == 3'd6);
      MD_WE_LO = valid & in_idle & (MD_FUNC == 3'd7);
      MD_D1    = RS_DATA;
      MD_D2    = RT_DATA;
      STALL    = valid & (~in_idle | (is_muldiv & MD_BUSY));
      RD_VALID = valid & in_idle & (MD_FUNC == 3'd4 || MD_FUNC == 3'd5);
      if (RD_VALID) RD_DATA = (MD_FUNC == 3'd4) ? MD_HI : MD_LO;
      DIV0     = start & MD_FUNC[1] & (RT_DATA == 32'd0);
      ERR      = err_q;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: a behavioural MD unit plus a cycle-count model of the
// controller, compared on every falling edge, and directed scenarios with literal expectations.
module tb_md_issue_ctrl;

  localparam int unsigned MAX_WAIT = 15;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        MD_VALID = 1'b0;
  logic [2:0]  MD_FUNC = 3'd0;
  logic [31:0] RS_DATA = 32'd0;
  logic [31:0] RT_DATA = 32'd0;
  logic        FLUSH = 1'b0;
  logic        MD_START, MD_WE_HI, MD_WE_LO, STALL, RD_VALID, DIV0, ERR;
  logic [1:0]  MD_OP;
  logic [31:0] MD_D1, MD_D2, RD_DATA;

  // Behavioural MD unit
  logic        u_busy = 1'b0;
  logic [31:0] u_hi = 32'd0, u_lo = 32'd0, u_a = 32'd0, u_b = 32'd0;
  logic [1:0]  u_op = 2'd0;
  int          u_cnt = 0;
  int          lat = 4;
  logic        stuck = 1'b0;

  // Controller model: m_age 0 = idle, 1 = first cycle after issue, 2 = waiting on BUSY
  int          m_age = 0;
  int          m_wcnt = 0;
  logic        m_err = 1'b0;

  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  md_issue_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MD_VALID(MD_VALID), .MD_FUNC(MD_FUNC),
    .RS_DATA(RS_DATA), .RT_DATA(RT_DATA), .FLUSH(FLUSH), .MD_BUSY(u_busy),
    .MD_HI(u_hi), .MD_LO(u_lo), .MD_START(MD_START), .MD_OP(MD_OP),
    .MD_WE_HI(MD_WE_HI), .MD_WE_LO(MD_WE_LO), .MD_D1(MD_D1), .MD_D2(MD_D2),
    .STALL(STALL), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .DIV0(DIV0), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] md_result(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    logic [63:0] r;
    r = {hi, lo};
    case (op)
      2'd0: r = {32'd0, a} * {32'd0, b};
      2'd1: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'd2: if (b != 0) r = {a % b, a / b};
      default: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endcase
    return r;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      u_busy <= 1'b0;
      u_hi   <= 32'd0;
      u_lo   <= 32'd0;
      u_cnt  <= 0;
    end else begin
      if (u_busy) begin
        if (!stuck && u_cnt <= 1) begin
          u_busy <= 1'b0;
          {u_hi, u_lo} <= md_result(u_op, u_a, u_b, u_hi, u_lo);
        end else if (u_cnt > 1) begin
          u_cnt <= u_cnt - 1;
        end
      end else if (MD_START) begin
        u_busy <= 1'b1;
        u_cnt  <= lat;
        u_op   <= MD_OP;
        u_a    <= MD_D1;
        u_b    <= MD_D2;
      end
      if (MD_WE_HI) u_hi <= MD_D1;
      if (MD_WE_LO) u_lo <= MD_D1;
    end
  end

  function automatic logic exp_start();
    return RESET_N && MD_VALID && !FLUSH && m_age == 0 && MD_FUNC < 3'd4 && !u_busy;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_age  <= 0;
      m_wcnt <= 0;
      m_err  <= 1'b0;
    end else if (m_age == 0) begin
      if (exp_start()) m_age <= 1;
    end else if (m_age == 1) begin
      m_age  <= 2;
      m_wcnt <= 0;
    end else if (!u_busy) begin
      m_age  <= 0;
      m_wcnt <= 0;
    end else if (m_wcnt + 1 == int'(MAX_WAIT)) begin
      m_err  <= 1'b1;
      m_age  <= 0;
      m_wcnt <= 0;
    end else begin
      m_wcnt <= m_wcnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin : compare
      logic v, idle, st, rdv;
      v    = RESET_N && MD_VALID && !FLUSH;
      idle = (m_age == 0);
      st   = exp_start();
      rdv  = v && idle && (MD_FUNC == 3'd4 || MD_FUNC == 3'd5);
      chk("m_start", 32'(MD_START), 32'(st));
      chk("m_op", 32'(MD_OP), st ? 32'(MD_FUNC[1:0]) : 32'd0);
      chk("m_we_hi", 32'(MD_WE_HI), 32'(v && idle && MD_FUNC == 3'd6));
      chk("m_we_lo", 32'(MD_WE_LO), 32'(v && idle && MD_FUNC == 3'd7));
      chk("m_stall", 32'(STALL), 32'(v && (!idle || (MD_FUNC < 3'd4 && u_busy))));
      chk("m_rd_valid", 32'(RD_VALID), 32'(rdv));
      chk("m_rd_data", RD_DATA, rdv ? ((MD_FUNC == 3'd4) ? u_hi : u_lo) : 32'd0);
      chk("m_div0", 32'(DIV0), 32'(st && MD_FUNC[1] && RT_DATA == 32'd0));
      chk("m_d1", MD_D1, RESET_N ? RS_DATA : 32'd0);
      chk("m_d2", MD_D2, RESET_N ? RT_DATA : 32'd0);
      chk("m_err", 32'(ERR), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    MD_VALID = v;
    MD_FUNC  = f;
    RS_DATA  = rs;
    RT_DATA  = rt;
    FLUSH    = fl;
  endtask

  // Leaves the bench at the falling edge of the first unstalled cycle.
  task automatic wait_unstalled(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (STALL && n < 40) begin
      step();
      @(negedge CLK);
      n++;
    end
    if (STALL) chk({name, "_timeout"}, 32'(STALL), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1 RESET_N = 1'b0;
    drive(1'b1, 3'd1, 32'hDEAD_BEEF, 32'd3, 1'b0);
    #2;
    chk("rst_start", 32'(MD_START), 32'd0);
    chk("rst_d1", MD_D1, 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk_en = 1'b1;
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step();
    RESET_N = 1'b1;
    step();

    // MULT -2 * 3, then MFLO / MFHI
    lat = 4;
    drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    @(negedge CLK);
    chk("mult_start", 32'(MD_START), 32'd1);
    chk("mult_op", 32'(MD_OP), 32'd1);
    chk("mult_stall", 32'(STALL), 32'd0);
    step();
    drive(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    chk("mult_pulse_once", 32'(MD_START), 32'd0);
    chk("mflo_stall_arm", 32'(STALL), 32'd1);
    wait_unstalled("mflo");
    chk("mflo_valid", 32'(RD_VALID), 32'd1);
    chk("mflo_data", RD_DATA, 32'hFFFF_FFFA);
    step();
    drive(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    chk("mfhi_data", RD_DATA, 32'hFFFF_FFFF);
    step();

    // DIVU 100 / 7 with MFHI back-to-back
    lat = 6;
    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    chk("divu_stall_arm", 32'(STALL), 32'd1);
    step();
    @(negedge CLK);
    chk("divu_stall_wait", 32'(STALL), 32'd1);
    wait_unstalled("divu_mfhi");
    chk("divu_rd_valid", 32'(RD_VALID), 32'd1);
    chk("divu_rem", RD_DATA, 32'd2);
    step();

    // MTHI then MFHI
    drive(1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge CLK);
    chk("mthi_we", 32'(MD_WE_HI), 32'd1);
    chk("mthi_stall", 32'(STALL), 32'd0);
    step();
    drive(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    chk("mthi_readback", RD_DATA, 32'h1234_5678);
    step();

    // DIV by zero keeps prior LO (quotient 14 from DIVU)
    lat = 3;
    drive(1'b1, 3'd3, 32'd5, 32'd0, 1'b0);
    @(negedge CLK);
    chk("div0_pulse", 32'(DIV0), 32'd1);
    chk("div0_start", 32'(MD_START), 32'd1);
    step();
    drive(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
    wait_unstalled("div0_mflo");
    chk("div0_lo_kept", RD_DATA, 32'd14);
    step();

    // FLUSH
    drive(1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    @(negedge CLK);
    chk("flush_no_start", 32'(MD_START), 32'd0);
    step();
    drive(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    chk("flush_still_idle", 32'(STALL), 32'd0);
    step();
    drive(1'b1, 3'd1, 32'd2, 32'd2, 1'b0);
    step();
    drive(1'b1, 3'd1, 32'd2, 32'd2, 1'b1);
    @(negedge CLK);
    chk("flush_arm_stall", 32'(STALL), 32'd0);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (8) step();

    // Watchdog: BUSY held for MAX_WAIT+2 cycles
    stuck = 1'b1;
    drive(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (MAX_WAIT) step();
    @(negedge CLK);
    chk("wd_err_before", 32'(ERR), 32'd0);
    step();
    stuck = 1'b0;
    @(negedge CLK);
    chk("wd_err_set", 32'(ERR), 32'd1);
    step();
    step();
    @(negedge CLK);
    chk("wd_err_sticky", 32'(ERR), 32'd1);

    // Asynchronous reset in the middle of an operation
    step();
    lat = 6;
    drive(1'b1, 3'd2, 32'd50, 32'd3, 1'b0);
    step();
    step();
    drive(1'b1, 3'd4, 32'h0000_ABCD, 32'd0, 1'b0);
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_stall", 32'(STALL), 32'd0);
    chk("arst_d1", MD_D1, 32'd0);
    chk("arst_err", 32'(ERR), 32'd0);
    step();
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("arst_idle", 32'(STALL), 32'd0);
    chk("arst_rd", RD_DATA, 32'd0);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
